// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg : shared flit types and output-register states for the NoC arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package noc_pkg;

  localparam int FLIT_W   = 9;
  localparam int ADDR_MSB = 8;
  localparam int ADDR_LSB = 5;
  localparam int ADDR_W   = 4;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [ADDR_W-1:0] noc_addr_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Destination field as seen by the downstream decoder tree.
  function automatic noc_addr_t flit_addr(input flit_t f);
    return f[ADDR_MSB:ADDR_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin grant, priority starts at ptr+1
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o,
  output logic [SW-1:0] grant_idx_o
);

  localparam int DW = 2 * N;

  logic [DW-1:0] dbl_req;
  logic [DW-1:0] mask;
  logic [DW-1:0] masked;
  logic          found;
  int            first;

  // Upper copy is never masked, so the lowest surviving bit is the wrap-around winner.
  always_comb begin
    dbl_req = {req_i, req_i};
    mask    = {DW{1'b1}} << (int'(ptr_i) + 1);
    masked  = dbl_req & mask;
    found   = |masked;
    first   = 0;
    for (int j = DW - 1; j >= 0; j--) begin
      if (masked[j]) first = j;
    end
    grant_idx_o = (first >= N) ? SW'(first - N) : SW'(first);
    grant_o     = (en_i && found) ? (N'(1) << grant_idx_o) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/noc_flit_rr_arbiter.sv
// ---------------------------------------------------------------------------
// noc_flit_rr_arbiter : N-way round-robin flit arbiter with one-entry output reg
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module noc_flit_rr_arbiter
  import noc_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = FLIT_W,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [N-1:0]   port_en,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  output logic           out_valid,
  input  logic           out_ready
);

  out_state_e    state_q;
  logic [W-1:0]  data_q;
  logic [SW-1:0] src_q;
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] ptr_d;

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [SW-1:0] grant_idx;
  logic          can_load;
  logic          load;
  logic [W-1:0]  win_flit;

  assign req      = in_valid & port_en;
  assign can_load = (state_q == OUT_EMPTY) || out_ready;

  rr_arbiter #(
    .N (N),
    .SW(SW)
  ) u_arb (
    .req_i      (req),
    .ptr_i      (ptr_q),
    .en_i       (can_load && !reset),
    .grant_o    (grant),
    .grant_idx_o(grant_idx)
  );

  assign in_ready = grant;
  assign load     = |grant;
  assign win_flit = in_data[int'(grant_idx)*W +: W];
  assign ptr_d    = load ? grant_idx : ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= SW'(N - 1);
    end else begin
      case (state_q)
        OUT_EMPTY: if (load) state_q <= OUT_FULL;
        OUT_FULL:  if (out_ready && !load) state_q <= OUT_EMPTY;
        default:   state_q <= OUT_EMPTY;
      endcase
      if (load) begin
        data_q <= win_flit;
        src_q  <= grant_idx;
      end
      ptr_q <= ptr_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

`default_nettype wire
